// File: rtl/cdc_test.sv
// Receives bytes from an asynchronous sender over a four-phase req/ack handshake.
// REQ is resynchronized into clk; the byte is captured on the synchronized rising edge.
module cdc_test #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [SYNC_STAGES-1:0] req_s_q, req_s_d;
  logic                   req_d_q, req_d_d;
  logic [7:0]             data_q, data_d;
  logic                   ack_q, ack_d;
  logic [5:0]             count_q, count_d;
  logic                   rise, fall;
  logic                   unused_ok;

  // ena and the upper uio inputs have no function in this design.
  assign unused_ok = ^{ena, uio_in[7:1]};

  always_comb begin
    req_s_d = {req_s_q[SYNC_STAGES-2:0], uio_in[0]};
    req_d_d = req_s_q[SYNC_STAGES-1];
    rise    = req_s_q[SYNC_STAGES-1] & ~req_d_q;
    fall    = ~req_s_q[SYNC_STAGES-1] & req_d_q;
    data_d  = data_q;
    ack_d   = ack_q;
    count_d = count_q;
    if (rise) begin
      data_d = ui_in;
      ack_d  = 1'b1;
    end
    if (fall) begin
      ack_d   = 1'b0;
      count_d = count_q + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_s_q <= '0;
      req_d_q <= 1'b0;
      data_q  <= 8'h00;
      ack_q   <= 1'b0;
      count_q <= 6'd0;
    end else begin
      req_s_q <= req_s_d;
      req_d_q <= req_d_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      count_q <= count_d;
    end
  end

  assign uo_out  = data_q;
  assign uio_out = {count_q, ack_q, 1'b0};
  assign uio_oe  = 8'b1111_1110;

endmodule

// File: tb/tb_cdc_test.sv
// Directed bench for cdc_test: reset behaviour, handshake latency, data stability,
// counter wrap, asynchronous reset mid-handshake and a short REQ glitch.
module tb_cdc_test;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  cdc_test #(.SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1ns so outputs are sampled away from the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%02h expected=0x%02h", tag, observed, expected);
    end
  endtask

  task automatic waitAck(input logic level, input string tag);
    for (int i = 0; i < 20; i++) begin
      if (uio_out[1] === level) break;
      step(1);
    end
    checkOutput(tag, {7'd0, uio_out[1]}, {7'd0, level});
  endtask

  // One complete four-phase transfer of byte b, following the sender protocol.
  task automatic applyStimulus(input logic [7:0] b);
    ui_in     = b;
    uio_in[0] = 1'b1;
    step(1);
    waitAck(1'b1, "hs_ack_rise");
    uio_in[0] = 1'b0;
    step(1);
    waitAck(1'b0, "hs_ack_fall");
  endtask

  task automatic pulseReset();
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    step(1);
  endtask

  bit ack_seen;

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'hA5;
    uio_in = 8'h01;

    // Reset with REQ already high
    #3;
    checkOutput("rst_uo_out", uo_out, 8'h00);
    checkOutput("rst_uio_out", uio_out, 8'h00);
    checkOutput("rst_uio_oe", uio_oe, 8'hFE);
    step(3);
    checkOutput("rst_hold_uio_out", uio_out, 8'h00);
    checkOutput("rst_hold_uo_out", uo_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    checkOutput("rst_rel_edge2_ack", uio_out, 8'h00);
    step(1);
    checkOutput("rst_rel_edge3_ack", uio_out, 8'h02);
    checkOutput("rst_rel_edge3_data", uo_out, 8'hA5);
    uio_in[0] = 1'b0;
    step(1);
    waitAck(1'b0, "rst_rel_ack_fall");
    ena = 1'b0;
    pulseReset();
    checkOutput("rst2_uio_out", uio_out, 8'h00);

    // Single transfer with exact latency
    ui_in     = 8'h3C;
    uio_in[0] = 1'b1;
    step(2);
    checkOutput("single_edge2_ack", uio_out, 8'h00);
    checkOutput("single_edge2_data", uo_out, 8'h00);
    step(1);
    checkOutput("single_edge3_ack", uio_out, 8'h02);
    checkOutput("single_edge3_data", uo_out, 8'h3C);

    // ui_in changes while REQ is high must not reach uo_out
    ui_in = 8'hFF;
    step(3);
    checkOutput("stable_data", uo_out, 8'h3C);
    uio_in[0] = 1'b0;
    step(2);
    checkOutput("single_fall_edge2", uio_out, 8'h02);
    step(1);
    checkOutput("single_fall_edge3", uio_out, 8'h04);
    checkOutput("single_fall_data", uo_out, 8'h3C);

    applyStimulus(8'h81);
    checkOutput("second_data", uo_out, 8'h81);
    checkOutput("second_count", uio_out, 8'h08);

    // Counter wrap from a clean reset
    pulseReset();
    for (int i = 0; i < 63; i++) applyStimulus(8'(i));
    checkOutput("wrap_count63", uio_out, 8'hFC);
    checkOutput("wrap_data62", uo_out, 8'h3E);
    applyStimulus(8'h3F);
    checkOutput("wrap_count0", uio_out, 8'h00);
    checkOutput("wrap_data63", uo_out, 8'h3F);

    // Asynchronous reset in the middle of a handshake
    for (int i = 0; i < 5; i++) applyStimulus(8'(8'h10 + i));
    ui_in     = 8'h5A;
    uio_in[0] = 1'b1;
    step(1);
    waitAck(1'b1, "mid_ack_rise");
    checkOutput("mid_pre_uio_out", uio_out, 8'h16);
    checkOutput("mid_pre_data", uo_out, 8'h5A);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_uio_out", uio_out, 8'h00);
    checkOutput("mid_rst_uo_out", uo_out, 8'h00);
    uio_in[0] = 1'b0;
    #2 rst_n = 1'b1;
    step(5);
    checkOutput("mid_post_uio_out", uio_out, 8'h00);
    checkOutput("mid_post_uo_out", uo_out, 8'h00);

    // One-clock REQ glitch: either ignored or a full rise/fall pair
    ui_in     = 8'h77;
    uio_in[0] = 1'b1;
    step(1);
    uio_in[0] = 1'b0;
    ack_seen  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (uio_out[1] === 1'b1) ack_seen = 1'b1;
      checkOutput("glitch_uio_oe", uio_oe, 8'hFE);
    end
    checkOutput("glitch_final", uio_out, ack_seen ? 8'h04 : 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
